// File: rtl/dmem_sized_if.sv
// dmem_sized_if: data-memory port between the core and dmem_sized
//   master: memwrite (store size), dataadr (byte address), writedata (right-aligned store data)
//   slave : readdata (word at dataadr), storecount (saturating), err (sticky), erraddr (first bad address)
interface dmem_sized_if;
    logic [1:0]  memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] storecount;
    logic        err;
    logic [31:0] erraddr;
    modport master (
        output memwrite, dataadr, writedata,
        input  readdata, storecount, err, erraddr
    );
    modport slave (
        input  memwrite, dataadr, writedata,
        output readdata, storecount, err, erraddr
    );
endinterface

// File: rtl/dmem_sized.sv
// dmem_sized: word RAM with sized little-endian stores, async word reads, store counter and sticky error capture
//   clk, reset (sync, active-low); bus: dmem_sized_if.slave
module dmem_sized #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input logic         clk,
    input logic         reset,
    dmem_sized_if.slave bus
);
    logic [31:0]   ram [DEPTH];
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          misaligned;
    logic          outrange;
    logic          bad;
    logic          ok;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   merged;
    always_comb begin
        idx        = bus.dataadr[AW+1:2];
        lane       = bus.dataadr[1:0];
        misaligned = (bus.memwrite == 2'b10 && lane[0]) || (bus.memwrite == 2'b11 && lane != 2'b00);
        outrange   = |bus.dataadr[31:AW+2];
        bad        = bus.memwrite != 2'b00 && (misaligned || outrange);
        ok         = bus.memwrite != 2'b00 && !bad;
        be         = bus.memwrite == 2'b01 ? 4'b0001 << lane :
                     bus.memwrite == 2'b10 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        // replicate store data across lanes so the byte enables alone pick the target lane
        wlanes     = bus.memwrite == 2'b01 ? {4{bus.writedata[7:0]}} :
                     bus.memwrite == 2'b10 ? {2{bus.writedata[15:0]}} : bus.writedata;
        merged     = ram[idx];
        for (int k = 0; k < 4; k++)
            merged[8*k +: 8] = be[k] ? wlanes[8*k +: 8] : ram[idx][8*k +: 8];
    end
    assign bus.readdata = ram[idx];
    always_ff @(posedge clk)
        if (reset && ok) ram[idx] <= merged;
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.storecount <= 16'd0;
            bus.err        <= 1'b0;
            bus.erraddr    <= 32'd0;
        end else if (bad) begin
            bus.err <= 1'b1;
            if (!bus.err) bus.erraddr <= bus.dataadr;
        end else if (ok && bus.storecount != 16'hFFFF) begin
            bus.storecount <= bus.storecount + 16'd1;
        end
    end
endmodule

// File: tb/tb_dmem_sized.sv
// tb_dmem_sized: directed stimulus against a byte-addressed reference model of dmem_sized
module tb_dmem_sized;
    localparam int DEPTH = 64;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    dmem_sized_if bus();
    dmem_sized #(.DEPTH(DEPTH), .AW(6)) dut (.clk(clk), .reset(reset), .bus(bus));
    logic [7:0]  mb [DEPTH*4];
    bit          kn [DEPTH*4];
    int unsigned m_cnt;
    bit          m_err;
    logic [31:0] m_ea;
    bit          en;
    int          checks;
    int          errors;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // reference: memory as a flat byte array, a store of size s writes s consecutive bytes
    function automatic void upd(input bit r, input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d);
        int sz;
        if (!r) begin
            m_cnt = 0;
            m_err = 0;
            m_ea  = 0;
            return;
        end
        if (mw == 2'b00) return;
        sz = 1 << (mw - 1);
        if (a % sz != 0 || a >= DEPTH * 4) begin
            if (!m_err) m_ea = a;
            m_err = 1;
        end else begin
            for (int i = 0; i < sz; i++) begin
                mb[a + i] = d[8*i +: 8];
                kn[a + i] = 1;
            end
            if (m_cnt < 65535) m_cnt++;
        end
    endfunction
    function automatic bit mword(input logic [31:0] a, output logic [31:0] w);
        int b;
        b = ((a / 4) % DEPTH) * 4;
        w = {mb[b + 3], mb[b + 2], mb[b + 1], mb[b]};
        return kn[b] && kn[b + 1] && kn[b + 2] && kn[b + 3];
    endfunction
    always @(negedge clk) begin
        logic [31:0] w;
        if (en) begin
            chk("storecount", {16'h0, bus.storecount}, m_cnt);
            chk("err", {31'h0, bus.err}, {31'h0, m_err});
            chk("erraddr", bus.erraddr, m_ea);
            if (mword(bus.dataadr, w)) chk("readdata", bus.readdata, w);
        end
    end
    task automatic cyc(input bit r, input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d);
        reset         = r;
        bus.memwrite  = mw;
        bus.dataadr   = a;
        bus.writedata = d;
        @(posedge clk);
        upd(r, mw, a, d);
        en = 1;
        @(negedge clk);
        #1;
    endtask
    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        bus.memwrite = 2'b00;
        bus.dataadr  = a;
        #1;
        chk(nm, bus.readdata, exp);
    endtask
    initial begin
        reset         = 1'b0;
        bus.memwrite  = 2'b00;
        bus.dataadr   = 32'd0;
        bus.writedata = 32'd0;
        @(negedge clk);
        #1;
        cyc(0, 2'b00, 0, 0);
        cyc(0, 2'b00, 0, 0);
        chk("rst_count", {16'h0, bus.storecount}, 32'd0);
        chk("rst_err", {31'h0, bus.err}, 32'd0);
        chk("rst_erraddr", bus.erraddr, 32'd0);
        cyc(1, 2'b11, 84, 32'hFFFF7F02);
        rd("word_84", 84, 32'hFFFF7F02);
        chk("word_count", {16'h0, bus.storecount}, 32'd1);
        chk("word_err", {31'h0, bus.err}, 32'd0);
        cyc(0, 2'b00, 0, 0);
        cyc(1, 2'b11, 0, 32'h11223344);
        cyc(1, 2'b01, 1, 32'h000000AA);
        cyc(1, 2'b01, 3, 32'h000000BB);
        rd("byte_merge", 0, 32'hBB22AA44);
        chk("byte_count", {16'h0, bus.storecount}, 32'd3);
        cyc(1, 2'b11, 8, 32'h0);
        cyc(1, 2'b10, 10, 32'h1234ABCD);
        cyc(1, 2'b10, 8, 32'h00005678);
        rd("half_merge", 8, 32'hABCD5678);
        cyc(1, 2'b00, 32'h400, 32'h1);
        chk("nop_no_err", {31'h0, bus.err}, 32'd0);
        cyc(1, 2'b11, 12, 32'hCAFEF00D);
        cyc(1, 2'b10, 13, 32'h0000FFFF);
        rd("misalign_ram", 12, 32'hCAFEF00D);
        chk("misalign_err", {31'h0, bus.err}, 32'd1);
        chk("misalign_addr", bus.erraddr, 32'd13);
        chk("misalign_count", {16'h0, bus.storecount}, 32'd7);
        cyc(1, 2'b11, 32'h400, 32'h1);
        chk("oor_addr", bus.erraddr, 32'd13);
        chk("oor_count", {16'h0, bus.storecount}, 32'd7);
        cyc(1, 2'b11, 4, 32'h01020304);
        cyc(0, 2'b11, 4, 32'hDEADBEEF);
        rd("rst_store_dropped", 4, 32'h01020304);
        chk("mid_rst_count", {16'h0, bus.storecount}, 32'd0);
        chk("mid_rst_err", {31'h0, bus.err}, 32'd0);
        chk("mid_rst_erraddr", bus.erraddr, 32'd0);
        cyc(1, 2'b11, 4, 32'hDEADBEEF);
        rd("after_rst_store", 4, 32'hDEADBEEF);
        rd("alias_upper_bits", 32'h10000007, 32'hDEADBEEF);
        chk("after_rst_count", {16'h0, bus.storecount}, 32'd1);
        cyc(1, 2'b11, 6, 32'h5);
        chk("misalign_word_addr", bus.erraddr, 32'd6);
        cyc(0, 2'b00, 0, 0);
        for (int i = 0; i < 65540; i++) cyc(1, 2'b01, 20 + (i % 4), i);
        chk("sat_count", {16'h0, bus.storecount}, 32'h0000FFFF);
        chk("sat_model", m_cnt, 32'd65535);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
